formula_result_collector: RTL and testbench

FORMULA_RESULT_COLLECTOR -- requirements
Module: formula_result_collector

---
 rtl/formula_result_collector.sv | 129 ++++++++++++
 tb/tb_formula_result_collector.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/formula_result_collector.sv
// formula_result_collector
//
// Collects results from a fixed- or variable-latency upstream pipe into a
// DEPTH-entry circular buffer. Issue slots are handed out only while there is
// room for every result already promised, so a well-behaved upstream pipe can
// never overflow the buffer regardless of its latency.
//
// Optional feature (compile-time macro FORMULA_RESULT_COLLECTOR_BYPASS_EN):
//   When defined, a result arriving while the buffer is empty is presented on
//   down_data in the same cycle. If the consumer takes it, it is never written
//   into the buffer. When undefined, results always pass through the buffer
//   and appear on the cycle after up_vld at the earliest.
//
// Parameters
//   WIDTH  result data width
//   DEPTH  buffer entries (power of 2, >= 2)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   issue_vld  upstream wants to issue an argument set
//   issue_rdy  a result slot is available for a new issue
//   up_vld     upstream result valid
//   up_data    upstream result
//   down_vld   a result is available to the consumer
//   down_data  oldest result
//   down_rdy   consumer accepts down_data
//   count      entries currently stored in the buffer
//   err        sticky protocol-error flag, cleared only by reset

module formula_result_collector #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_vld,
    output logic                     issue_rdy,
    input  logic                     up_vld,
    input  logic [WIDTH-1:0]         up_data,
    output logic                     down_vld,
    output logic [WIDTH-1:0]         down_data,
    input  logic                     down_rdy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] reserved;
    logic [PW-1:0] stored;
    logic          err_q;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic issue_acc;
    logic bypass_take;
    logic err_set;

    // Reserved slots never go below zero: an unsolicited result (already
    // flagged as an error) can make a pop outnumber the reservations.
    function automatic logic [PW-1:0] reserved_next(input logic [PW-1:0] cur,
                                                    input logic          inc,
                                                    input logic          dec);
        if (inc && !dec)
            return cur + PW'(1);
        else if (!inc && dec && (cur != '0))
            return cur - PW'(1);
        return cur;
    endfunction

    always_comb begin
        stored    = wr_ptr - rd_ptr;
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        issue_rdy = rst && (reserved < DEPTH_P);
`ifdef FORMULA_RESULT_COLLECTOR_BYPASS_EN
        down_vld    = rst && (!empty || up_vld);
        down_data   = empty ? up_data : mem[rd_ptr[AW-1:0]];
        bypass_take = rst && empty && up_vld && down_rdy;
`else
        down_vld    = rst && !empty;
        down_data   = mem[rd_ptr[AW-1:0]];
        bypass_take = 1'b0;
`endif
        pop       = down_vld && down_rdy;
        // A full buffer still accepts a result when a pop frees a slot
        // in the same cycle.
        push      = up_vld && (!full || pop) && !bypass_take;
        issue_acc = issue_vld && issue_rdy;
        err_set   = (issue_vld && !issue_rdy)
                 || (up_vld && full && !pop)
                 || (up_vld && (reserved == stored));
        count     = stored;
        err       = err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            reserved <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop && !bypass_take)
                rd_ptr <= rd_ptr + PW'(1);
            reserved <= reserved_next(reserved, issue_acc, pop);
            if (err_set)
                err_q <= 1'b1;
        end
    end

    // Storage is data only and is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= up_data;
    end

endmodule

// File: tb/tb_formula_result_collector.sv
// Testbench for formula_result_collector (DEPTH=4, WIDTH=32).
// Inputs are driven on the falling edge, outputs are compared 1 ns later
// against a queue-based reference model, and the model advances on the
// following rising edge. Honours FORMULA_RESULT_COLLECTOR_BYPASS_EN.

module tb_formula_result_collector;

    localparam int W = 32;
    localparam int D = 4;
`ifdef FORMULA_RESULT_COLLECTOR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         issue_vld;
    logic         issue_rdy;
    logic         up_vld;
    logic [W-1:0] up_data;
    logic         down_vld;
    logic [W-1:0] down_data;
    logic         down_rdy;
    logic [2:0]   count;
    logic         err;

    formula_result_collector #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue_vld (issue_vld),
        .issue_rdy (issue_rdy),
        .up_vld    (up_vld),
        .up_data   (up_data),
        .down_vld  (down_vld),
        .down_data (down_data),
        .down_rdy  (down_rdy),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the buffered results, the number of promised slots,
    // and the sticky error flag.
    logic [W-1:0] mq[$];
    int           m_res = 0;
    bit           m_err = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_down_vld();
        return (mq.size() > 0) || (BYP && up_vld);
    endfunction

    task automatic compare_model(input string tag);
        chk({tag, ".issue_rdy"}, W'(issue_rdy), W'(m_res < D));
        chk({tag, ".down_vld"},  W'(down_vld),  W'(m_down_vld()));
        if (m_down_vld())
            chk({tag, ".down_data"}, down_data, (mq.size() > 0) ? mq[0] : up_data);
        chk({tag, ".count"}, W'(count), W'(mq.size()));
        chk({tag, ".err"},   W'(err),   W'(m_err));
    endtask

    // Apply one input vector at the falling edge and compare outputs.
    task automatic drive(input logic iv, input logic uv, input logic [W-1:0] ud,
                         input logic dr, input string tag);
        @(negedge clk);
        issue_vld = iv;
        up_vld    = uv;
        up_data   = ud;
        down_rdy  = dr;
        #1;
        compare_model(tag);
    endtask

    // Advance the model with the current inputs, then pass the rising edge.
    task automatic tick();
        bit rdy, pop, take, acc, full;
        rdy  = (m_res < D);
        pop  = m_down_vld() && down_rdy;
        take = BYP && (mq.size() == 0) && up_vld && down_rdy;
        acc  = issue_vld && rdy;
        full = (mq.size() == D);
        if (issue_vld && !rdy) m_err = 1'b1;
        if (up_vld && (m_res == mq.size())) m_err = 1'b1;
        if (pop && !take) void'(mq.pop_front());
        if (up_vld && !take) begin
            if (!full || pop) mq.push_back(up_data);
            else              m_err = 1'b1;
        end
        m_res = m_res + int'(acc) - int'(pop);
        if (m_res < 0) m_res = 0;
        @(posedge clk);
    endtask

    task automatic cyc(input logic iv, input logic uv, input logic [W-1:0] ud,
                       input logic dr, input string tag);
        drive(iv, uv, ud, dr, tag);
        tick();
    endtask

    task automatic model_reset();
        mq.delete();
        m_res = 0;
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        issue_vld = 0; up_vld = 0; up_data = '0; down_rdy = 0;
        #1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel.issue_rdy", W'(issue_rdy), 1);
        @(posedge clk);
    endtask

    logic [W-1:0] seq_d [4];
    int           pend;

    initial begin
        seq_d[0] = 32'h11; seq_d[1] = 32'h22; seq_d[2] = 32'h33; seq_d[3] = 32'h44;
        rst = 1'b0;
        issue_vld = 0; up_vld = 0; up_data = '0; down_rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.down_vld",  W'(down_vld),  0);
        chk("rst.issue_rdy", W'(issue_rdy), 0);
        chk("rst.count",     W'(count),     0);
        chk("rst.err",       W'(err),       0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel.issue_rdy", W'(issue_rdy), 1);
        @(posedge clk);

        // Four issues with the consumer stalled.
        for (int i = 0; i < 4; i++) cyc(1, 0, '0, 0, "fill_issue");
        drive(0, 0, '0, 0, "full_res");
        chk("full_res.issue_rdy", W'(issue_rdy), 0);
        tick();
        for (int i = 0; i < 4; i++) cyc(0, 1, seq_d[i], 0, "fill_res");
        drive(0, 0, '0, 0, "filled");
        chk("filled.count", W'(count), 4);
        chk("filled.err",   W'(err),   0);
        tick();

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, '0, 1, "drain");
            chk("drain.order", down_data, seq_d[i]);
            tick();
            if (i == 0) begin
                #1;
                chk("drain.issue_rdy", W'(issue_rdy), 1);
            end
        end

        // Continuous issue/result/pop, wrapping the pointers.
        cyc(1, 0, '0, 1, "cont_warm");
        for (int i = 0; i < 10; i++) cyc(1, 1, 32'h100 + i, 1, "cont");
        cyc(0, 1, 32'h10A, 1, "cont_tail");
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, "cont_flush");
        drive(0, 0, '0, 1, "cont_end");
        chk("cont_end.err", W'(err), 0);
        tick();

        // Random protocol-legal traffic with a variable-latency upstream.
        for (int i = 0; i < 300; i++) begin
            logic iv, uv, dr;
            pend = m_res - mq.size();
            iv = (m_res < D) && ($urandom_range(0, 3) != 0);
            uv = (pend > 0) && ($urandom_range(0, 2) != 0);
            dr = ($urandom_range(0, 2) != 0);
            cyc(iv, uv, $urandom, dr, "rand_legal");
        end
        for (int i = 0; i < 8; i++) cyc(0, m_res > mq.size(), $urandom, 1, "rand_flush");

        // Mid-stream reset with three entries stored.
        model_reset();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, '0, 0, "mid_issue");
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h200 + i, 0, "mid_res");
        drive(0, 0, '0, 0, "mid_pre");
        chk("mid_pre.count", W'(count), 3);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst.down_vld",  W'(down_vld),  0);
        chk("mid_rst.count",     W'(count),     0);
        chk("mid_rst.issue_rdy", W'(issue_rdy), 0);
        chk("mid_rst.err",       W'(err),       0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rel.issue_rdy", W'(issue_rdy), 1);
        @(posedge clk);

        // Issue while not ready: reservation held, error raised.
        for (int i = 0; i < 4; i++) cyc(1, 0, '0, 0, "ovr_fill");
        cyc(1, 0, '0, 0, "ovr_issue");
        drive(0, 0, '0, 0, "ovr_after");
        chk("ovr_after.err",       W'(err),       1);
        chk("ovr_after.issue_rdy", W'(issue_rdy), 0);
        tick();

        // Same-cycle path when empty.
        do_reset();
        cyc(1, 0, '0, 0, "byp_issue");
        drive(0, 1, 32'hABCD, 1, "byp");
`ifdef FORMULA_RESULT_COLLECTOR_BYPASS_EN
        chk("byp.down_vld",  W'(down_vld), 1);
        chk("byp.down_data", down_data,    32'hABCD);
`else
        chk("byp.down_vld",  W'(down_vld), 0);
`endif
        tick();
        drive(0, 0, '0, 1, "byp_next");
`ifdef FORMULA_RESULT_COLLECTOR_BYPASS_EN
        chk("byp_next.count", W'(count), 0);
`else
        chk("byp_next.down_vld",  W'(down_vld), 1);
        chk("byp_next.down_data", down_data,    32'hABCD);
`endif
        tick();

        // Unconstrained random traffic, including protocol violations.
        do_reset();
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom_range(0, 1), "rand_any");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
